// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode values, ALU operation
// encoding and the packed control bundle carried into the ID/EX register.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    illegal;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
        branch: 1'b0, jump: 1'b0, illegal: 1'b0, alu_op: ALU_ADD
    };

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control bundle, destination register,
// rt-usage flag for hazard detection, and the extended immediate.
module id_decoder
    import id_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [31:0]          instr,
    output ctrl_t                ctrl,
    output logic [4:0]           dest,
    output logic                 uses_rt,
    output logic [DATAWIDTH-1:0] imm
);

    logic [5:0] opcode_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic       rw_raw_s;

    assign opcode_s = instr[31:26];
    assign rt_s     = instr[20:16];
    assign rd_s     = instr[15:11];

    // Jumps carry an unsigned 26-bit target; everything else a signed imm16.
    assign imm = (opcode_s == OP_J) ? {{(DATAWIDTH-26){1'b0}}, instr[25:0]}
                                    : {{(DATAWIDTH-16){instr[15]}}, instr[15:0]};

    // Opcode to control bundle; a zero destination never writes the regfile.
    always_comb begin
        ctrl     = CTRL_NONE;
        dest     = 5'd0;
        uses_rt  = 1'b0;
        rw_raw_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                rw_raw_s    = 1'b1;
                dest        = rd_s;
                uses_rt     = 1'b1;
                ctrl.alu_op = ALU_FUNCT;
            end
            OP_LW: begin
                rw_raw_s      = 1'b1;
                dest          = rt_s;
                ctrl.mem_read = 1'b1;
                ctrl.alu_src  = 1'b1;
            end
            OP_SW: begin
                uses_rt        = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                rw_raw_s     = 1'b1;
                dest         = rt_s;
                ctrl.alu_src = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        ctrl.reg_write = rw_raw_s & (dest != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, load-use hazard bubble, flush, and the
// valid/ready ID/EX pipeline register feeding execute.
module id_stage
    import id_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DATAWIDTH-1:0] in_pc,
    input  logic                 flush,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [DATAWIDTH-1:0] rf_rdata1,
    input  logic [DATAWIDTH-1:0] rf_rdata2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_rs_val,
    output logic [DATAWIDTH-1:0] out_rt_val,
    output logic [DATAWIDTH-1:0] out_imm,
    output logic [4:0]           out_dest,
    output logic [5:0]           out_funct,
    output logic [DATAWIDTH-1:0] out_pc,
    output logic [1:0]           out_alu_op,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_alu_src,
    output logic                 out_branch,
    output logic                 out_jump,
    output logic                 out_illegal,
    output logic [15:0]          stall_cnt
);

    ctrl_t                ctrl_s;
    ctrl_t                ctrl_r;
    logic [4:0]           dest_s;
    logic                 uses_rt_s;
    logic [DATAWIDTH-1:0] imm_s;
    logic [4:0]           rs_s;
    logic [4:0]           rt_s;
    logic                 hazard_s;
    logic                 accept_s;

    id_decoder #(.DATAWIDTH(DATAWIDTH)) u_decoder (
        .instr   (in_instr),
        .ctrl    (ctrl_s),
        .dest    (dest_s),
        .uses_rt (uses_rt_s),
        .imm     (imm_s)
    );

    assign rs_s      = in_instr[25:21];
    assign rt_s      = in_instr[20:16];
    assign rf_raddr1 = rs_s;
    assign rf_raddr2 = rt_s;

    // A load still in ID/EX cannot supply its result to a dependent consumer.
    assign hazard_s = in_valid & out_valid & ctrl_r.mem_read & (out_dest != 5'd0)
                    & ((out_dest == rs_s) | (uses_rt_s & (out_dest == rt_s)));
    assign in_ready = ~flush & ~hazard_s & (~out_valid | out_ready);
    assign accept_s = in_valid & in_ready;

    assign out_alu_op    = ctrl_r.alu_op;
    assign out_reg_write = ctrl_r.reg_write;
    assign out_mem_read  = ctrl_r.mem_read;
    assign out_mem_write = ctrl_r.mem_write;
    assign out_alu_src   = ctrl_r.alu_src;
    assign out_branch    = ctrl_r.branch;
    assign out_jump      = ctrl_r.jump;
    assign out_illegal   = ctrl_r.illegal;

    // ID/EX register: flush wins, then accept, then drain into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ctrl_r     <= CTRL_NONE;
            out_rs_val <= {DATAWIDTH{1'b0}};
            out_rt_val <= {DATAWIDTH{1'b0}};
            out_imm    <= {DATAWIDTH{1'b0}};
            out_pc     <= {DATAWIDTH{1'b0}};
            out_dest   <= 5'd0;
            out_funct  <= 6'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid  <= 1'b1;
            ctrl_r     <= ctrl_s;
            out_rs_val <= rf_rdata1;
            out_rt_val <= rf_rdata2;
            out_imm    <= imm_s;
            out_pc     <= in_pc;
            out_dest   <= dest_s;
            out_funct  <= in_instr[5:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles spent in a load-use hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (hazard_s && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
